reverse_arbiter: RTL and testbench
==================================

# reverse_arbiter

Shares one bit-reversal datapath (`reverse` instance, WIDTH bits) between two streaming requesters. Each beat carries a per-beat mode bit selecting bit-reverse or pass-through. Arbitration is round-robin with bounded bursts of up to MAX_BURST beats per grant. The result is registered into a single-entry output stage with a valid/ready handshake, and tagged with the source requester. It sits between the fill/drain agents and the buffet storage wherever bit-order conversion is required.

## Interface
- WIDTH, 32, data width in bits (>=1)
- MAX_BURST, 4, max consecutive beats granted to one requester (>=1)
- clk  input  1  clock, all state on rising edge
- nreset  input  1  synchronous, active-low reset
- in0_valid  input  1  requester 0 beat valid
- in0_ready  output  1  requester 0 beat accepted this cycle
- in0_data  input  WIDTH  requester 0 payload
- in0_rev  input  1  1 = bit-reverse, 0 = pass-through
- in1_valid / in1_ready / in1_data / in1_rev  same as requester 0, for requester 1
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  processed payload
- out_src  output  1  requester index of out_data

## Operation
- Transfer on port n: inN_valid & inN_ready. At most one input transfer per cycle.
- pipe_ready = !out_valid | out_ready.
- inN_ready = pipe_ready & grant==n & nreset. Both readies are 0 while nreset is low.
- Internal state: owner ∈ {NONE, R0, R1}, beat count cnt (width $clog2(MAX_BURST+1)), priority pointer last (last served requester).
- Grant, evaluated each cycle:
  - Owner Rn with inN_valid=1: grant n.
  - Owner NONE, or owner Rn with inN_valid=0 (burst released; last←n): grant the only valid requester. If both are valid, grant !last. If neither is valid, no grant.
- On a transfer by g:
  - If g is the current owner, cnt←cnt+1. Otherwise owner←Rg and cnt←1.
  - If the new cnt==MAX_BURST: owner←NONE, cnt←0, last←g.
  - MAX_BURST=1 therefore degenerates to strict round-robin alternation.
- No transfer while the owner's valid is low: owner←NONE, cnt←0, last←owner.
- No transfer due to stall (pipe_ready=0): owner, cnt, and last hold. Grant stays stable, so a stalled requester is never pre-empted mid-stall.
- Datapath: selected data goes through `reverse` when the selected rev=1 and passes unchanged when rev=0. The result loads into out_data/out_src on transfer.
- out_valid: set on transfer. Cleared when out_ready & !transfer. Held otherwise.
- Requesters need not hold valid once asserted. Dropping valid simply releases ownership; no error is flagged.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle with out_ready held high, including across burst boundaries. Releasing ownership costs no bubble; the other requester is granted in the same cycle.
- The output stage is a single register with no skid buffer. in*_ready depends combinationally on out_ready.
- Reset (nreset low at an edge): out_valid←0, out_data←0, out_src←0, owner←NONE, cnt←0, last←1 (requester 0 wins the first contention). Reset mid-burst or mid-stall discards the in-flight output beat.
- Simultaneous out_ready and new transfer: the old beat leaves and the new beat loads in the same edge.

## Structure
- Shared package `buffet_pkg`: owner encoding localparams (OWN_NONE, OWN_R0, OWN_R1).
- Counter width is computed locally.
- Single sub-module: the existing `reverse` (WIDTH parameter passed through), instantiated once on the muxed data.
- Arbitration FSM and output register live in this module.

## Test plan
- Reset, then in0 sends 0x0000_0001 with rev=1 -> out_data=0x8000_0000, out_src=0, out_valid one cycle after the transfer. Send 0x1234_5678 with rev=0 -> 0x1234_5678 out unchanged.
- Both requesters continuously valid, MAX_BURST=4, out_ready=1 -> out_src sequence 0,0,0,0,1,1,1,1,0,… with no idle cycles.
- in0 owns the grant and drops valid after 2 beats while in1 is valid -> in1 is granted in the same cycle; the next contention grants in1 only after in0 has completed its turn (last=0 → priority to 1 confirmed).
- out_ready=0 for 5 cycles with a beat held, both inputs valid -> both in*_ready=0, out_data stable, and after release the owner and cnt resume unchanged (the burst completes its remaining beats).
- nreset pulsed low for 1 cycle mid-burst (cnt=2, out_valid=1) -> out_valid=0, out_data=0, and in0 wins the next contention.
- MAX_BURST=1, both valid -> strict alternation 0,1,0,1. WIDTH=8 with 0xA0, rev=1 -> 0x05.

Source files
------------

// File: rtl/buffet_pkg.sv
// Shared definitions for the buffet datapath blocks.
package buffet_pkg;

    // Arbitration owner encoding: who currently holds a burst grant.
    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_R0   = 2'd1;
    localparam owner_t OWN_R1   = 2'd2;

endpackage

// File: rtl/reverse.sv
// Pure combinational bit-order reversal: out bit i is in bit WIDTH-1-i.
module reverse #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    // Wire each output bit to its mirror input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out_data[i] = in_data[WIDTH-1-i];
    end

endmodule

// File: rtl/reverse_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts in front of one
// shared bit-reversal datapath, feeding a single-entry valid/ready output.
module reverse_arbiter
    import buffet_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_rev,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_rev,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src
);

    localparam int CW = $clog2(MAX_BURST + 1);

    owner_t          owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            last, last_nxt;

    logic            owner_hit;   // current owner still presenting a beat
    logic            rel_last;    // priority pointer once a stale owner is released
    logic            grant_vld;
    logic            grant;
    logic            pipe_ready;
    logic            xfer;

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] rev_data;
    logic             sel_rev;

    assign pipe_ready = !out_valid || out_ready;
    assign xfer       = grant_vld && pipe_ready && nreset;
    assign in0_ready  = pipe_ready && grant_vld && !grant && nreset;
    assign in1_ready  = pipe_ready && grant_vld &&  grant && nreset;

    // Grant: the owner keeps the datapath while valid; otherwise round-robin
    // against the last served requester, counting a released owner as served.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        owner_hit = 1'b0;
        rel_last  = last;
        if (owner == OWN_R0 && in0_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b0;
            owner_hit = 1'b1;
        end else if (owner == OWN_R1 && in1_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
            owner_hit = 1'b1;
        end else begin
            if (owner == OWN_R0)      rel_last = 1'b0;
            else if (owner == OWN_R1) rel_last = 1'b1;
            if (in0_valid && in1_valid) begin
                grant_vld = 1'b1;
                grant     = !rel_last;
            end else if (in0_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b0;
            end else if (in1_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b1;
            end
        end
    end

    // Burst bookkeeping: count beats of the owner, release at MAX_BURST or
    // when the owner goes idle; a pure stall leaves everything untouched.
    always_comb begin
        owner_nxt = owner;
        cnt_nxt   = cnt;
        last_nxt  = last;
        if (xfer) begin
            last_nxt = rel_last;
            if (owner_hit) begin
                cnt_nxt = cnt + 1'b1;
            end else begin
                owner_nxt = grant ? OWN_R1 : OWN_R0;
                cnt_nxt   = CW'(1);
            end
            if (cnt_nxt == CW'(MAX_BURST)) begin
                owner_nxt = OWN_NONE;
                cnt_nxt   = '0;
                last_nxt  = grant;
            end
        end else if (owner != OWN_NONE && !owner_hit) begin
            owner_nxt = OWN_NONE;
            cnt_nxt   = '0;
            last_nxt  = rel_last;
        end
    end

    // Arbitration state register; after reset requester 0 wins first contention.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            owner <= OWN_NONE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    assign sel_data = grant ? in1_data : in0_data;
    assign sel_rev  = grant ? in1_rev  : in0_rev;

    reverse #(.WIDTH(WIDTH)) u_reverse (
        .in_data  (sel_data),
        .out_data (rev_data)
    );

    // Single-entry output stage: load on transfer, drain when consumed.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_rev ? rev_data : sel_data;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reverse_arbiter.sv
// Directed bench for reverse_arbiter: a 32-bit/4-beat instance and an
// 8-bit/1-beat instance sharing clock and reset.
module tb_reverse_arbiter;

    logic clk = 1'b0;
    logic nreset;

    logic        a_in0_valid, a_in0_ready, a_in0_rev;
    logic [31:0] a_in0_data;
    logic        a_in1_valid, a_in1_ready, a_in1_rev;
    logic [31:0] a_in1_data;
    logic        a_out_valid, a_out_ready, a_out_src;
    logic [31:0] a_out_data;

    logic        b_in0_valid, b_in0_ready, b_in0_rev;
    logic [7:0]  b_in0_data;
    logic        b_in1_valid, b_in1_ready, b_in1_rev;
    logic [7:0]  b_in1_data;
    logic        b_out_valid, b_out_ready, b_out_src;
    logic [7:0]  b_out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reverse_arbiter #(.WIDTH(32), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .nreset(nreset),
        .in0_valid(a_in0_valid), .in0_ready(a_in0_ready), .in0_data(a_in0_data), .in0_rev(a_in0_rev),
        .in1_valid(a_in1_valid), .in1_ready(a_in1_ready), .in1_data(a_in1_data), .in1_rev(a_in1_rev),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_src(a_out_src)
    );

    reverse_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .nreset(nreset),
        .in0_valid(b_in0_valid), .in0_ready(b_in0_ready), .in0_data(b_in0_data), .in0_rev(b_in0_rev),
        .in1_valid(b_in1_valid), .in1_ready(b_in1_ready), .in1_data(b_in1_data), .in1_rev(b_in1_rev),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_src(b_out_src)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
    endtask

    initial begin
        logic [8:0] seq;
        nreset = 1'b0;
        a_in0_valid = 0; a_in0_data = '0; a_in0_rev = 0;
        a_in1_valid = 0; a_in1_data = '0; a_in1_rev = 0;
        a_out_ready = 1;
        b_in0_valid = 0; b_in0_data = '0; b_in0_rev = 0;
        b_in1_valid = 0; b_in1_data = '0; b_in1_rev = 0;
        b_out_ready = 1;
        tick(); tick();

        // Reset state; readies stay low while in reset even with valid.
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_out_src", 32'(a_out_src), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        a_in0_valid = 1; a_in1_valid = 1;
        #1;
        chk("rst_in0_ready", 32'(a_in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(a_in1_ready), 32'd0);
        a_in1_valid = 0;

        // Single beats: reversed then pass-through.
        nreset = 1'b1;
        a_in0_data = 32'h0000_0001; a_in0_rev = 1;
        #1;
        chk("b1_in0_ready", 32'(a_in0_ready), 32'd1);
        chk("b1_in1_ready", 32'(a_in1_ready), 32'd0);
        chk("b1_pre_valid", 32'(a_out_valid), 32'd0);
        tick();
        chk("b1_valid", 32'(a_out_valid), 32'd1);
        chk("b1_data", a_out_data, 32'h8000_0000);
        chk("b1_src", 32'(a_out_src), 32'd0);
        a_in0_data = 32'h1234_5678; a_in0_rev = 0;
        tick();
        chk("b2_data", a_out_data, 32'h1234_5678);
        a_in0_valid = 0;
        tick();
        chk("b2_drain", 32'(a_out_valid), 32'd0);

        // Continuous contention: bursts of 4, no bubbles.
        rst_pulse();
        a_in0_valid = 1; a_in0_data = 32'hAA; a_in0_rev = 0;
        a_in1_valid = 1; a_in1_data = 32'hBB; a_in1_rev = 0;
        seq = 9'b0_1111_0000;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("burst_valid%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("burst_src%0d", i), 32'(a_out_src), 32'(seq[i]));
            chk($sformatf("burst_data%0d", i), a_out_data, seq[i] ? 32'hBB : 32'hAA);
        end

        // Stall mid-burst (in0 at cnt=2): held beat stable, readies low.
        tick();
        chk("stall_pre_src", 32'(a_out_src), 32'd0);
        a_out_ready = 0;
        a_in0_data = 32'hCC;
        #1;
        chk("stall_in0_ready", 32'(a_in0_ready), 32'd0);
        chk("stall_in1_ready", 32'(a_in1_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("stall_data%0d", i), a_out_data, 32'hAA);
            chk($sformatf("stall_r0_%0d", i), 32'(a_in0_ready), 32'd0);
            chk($sformatf("stall_r1_%0d", i), 32'(a_in1_ready), 32'd0);
        end
        a_out_ready = 1;
        tick();
        chk("resume0_src", 32'(a_out_src), 32'd0);
        chk("resume0_data", a_out_data, 32'hCC);
        tick();
        chk("resume1_src", 32'(a_out_src), 32'd0);
        tick();
        chk("resume2_src", 32'(a_out_src), 32'd1);
        chk("resume2_data", a_out_data, 32'hBB);

        // Owner drops valid after 2 beats: in1 granted the same cycle.
        a_in0_data = 32'hAA;
        rst_pulse();
        tick(); tick();
        chk("drop_pre_src", 32'(a_out_src), 32'd0);
        a_in0_valid = 0;
        #1;
        chk("drop_in1_ready", 32'(a_in1_ready), 32'd1);
        chk("drop_in0_ready", 32'(a_in0_ready), 32'd0);
        tick();
        chk("drop_src", 32'(a_out_src), 32'd1);
        chk("drop_data", a_out_data, 32'hBB);

        // Released in0 burst counts as served: next contention favours in1.
        rst_pulse();
        a_in1_valid = 0; a_in0_valid = 1;
        tick(); tick();
        a_in0_valid = 0;
        tick();
        chk("idle_valid", 32'(a_out_valid), 32'd0);
        a_in0_valid = 1; a_in1_valid = 1;
        #1;
        chk("prio_in1_ready", 32'(a_in1_ready), 32'd1);
        chk("prio_in0_ready", 32'(a_in0_ready), 32'd0);
        tick();
        chk("prio_src", 32'(a_out_src), 32'd1);

        // Reset mid-burst of in1 (cnt=2): beat discarded, in0 wins after.
        rst_pulse();
        a_in0_valid = 0;
        tick(); tick();
        chk("mid_pre_valid", 32'(a_out_valid), 32'd1);
        chk("mid_pre_src", 32'(a_out_src), 32'd1);
        a_in0_valid = 1;
        nreset = 1'b0;
        #1;
        chk("mid_rst_r0", 32'(a_in0_ready), 32'd0);
        chk("mid_rst_r1", 32'(a_in1_ready), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_data", a_out_data, 32'd0);
        nreset = 1'b1;
        #1;
        chk("mid_post_r0", 32'(a_in0_ready), 32'd1);
        chk("mid_post_r1", 32'(a_in1_ready), 32'd0);
        tick();
        chk("mid_post_src", 32'(a_out_src), 32'd0);
        chk("mid_post_data", a_out_data, 32'hAA);

        // MAX_BURST=1, WIDTH=8: strict alternation, 0xA0 reversed is 0x05.
        b_in0_valid = 1; b_in0_data = 8'hA0; b_in0_rev = 1;
        b_in1_valid = 1; b_in1_data = 8'h3C; b_in1_rev = 0;
        #1;
        chk("alt_in0_ready", 32'(b_in0_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("alt_src%0d", i), 32'(b_out_src), 32'(i % 2));
            chk($sformatf("alt_data%0d", i), 32'(b_out_data), (i % 2) ? 32'h3C : 32'h05);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
